// File: rtl/counters_pkg.sv
// Shared helpers for the decimal counter family: prescaler sizing,
// seven-segment patterns and elaboration-time BCD conversion.
package counters_pkg;

  // Bit width needed to hold value, never less than 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Largest count value (modulus-1) as 8 packed BCD digits, digit 0 in [3:0].
  function automatic logic [31:0] mod_to_bcd(input int modulus);
    logic [31:0] r;
    int v;
    v = modulus - 1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit: steps up or down when cin is set, with carry/borrow out,
// and a synchronous load that wins over stepping.
module bcd_digit
  import counters_pkg::*;
(
  input  logic       clk,
  input  logic       aclr,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       cout
);

  assign cout = cin && ((inc && (q == 4'd9)) || (dec && (q == 4'd0)));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (cin && inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end else if (cin && dec) begin
      q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/counter_bcd_n.sv
// N-digit BCD counter with prescaler, up/down, validated load, arbitrary
// modulus and active-low seven-segment decode per digit.
module counter_bcd_n
  import counters_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000000,
  parameter int MOD    = 10000
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int                PC_W     = clogb2(DIV - 1);
  localparam int                CW       = 4 * DIGITS;
  localparam logic [31:0]       MAX_FULL = mod_to_bcd(MOD);
  localparam logic [CW-1:0]     MAX_BCD  = MAX_FULL[CW-1:0];
  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(DIV - 1);

  logic [PC_W-1:0] pc;
  logic            tick_int;
  logic            wrap_now;
  logic            step;
  logic            ld_all;
  logic            load_ok;
  logic [CW-1:0]   ld_data;
  logic [DIGITS:0] chain;
  logic            unused_msd_carry;

  assign tick_int = en && (pc == PC_LAST);

  // With all digits valid, BCD order equals numeric order, so one compare
  // against MOD-1 covers the range check.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    if (load_val > MAX_BCD) load_ok = 1'b0;
  end

  // Wrap is done as a parallel load of 0 or MOD-1 rather than via the carry chain.
  assign wrap_now = tick_int && !load && (up ? (cnt == MAX_BCD) : (cnt == '0));
  assign step     = tick_int && !load && !wrap_now;
  assign ld_all   = load || wrap_now;
  assign ld_data  = load ? (load_ok ? load_val : '0) : (up ? '0 : MAX_BCD);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pc <= '0;
    end else if (load) begin
      pc <= '0;
    end else if (en) begin
      pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
    end
  end

  assign chain[0]         = step;
  assign unused_msd_carry = chain[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .aclr   (aclr),
      .inc    (up),
      .dec    (!up),
      .cin    (chain[g]),
      .ld     (ld_all),
      .ld_val (ld_data[4*g +: 4]),
      .q      (cnt[4*g +: 4]),
      .cout   (chain[g+1])
    );
    assign hex[7*g +: 7] = seg_decode(cnt[4*g +: 4]);
  end

  // Output pulse registers, aligned with the cycle the new count is visible.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= tick_int && !load;
      wrap     <= wrap_now;
      load_err <= load && !load_ok;
    end
  end

endmodule

// File: tb/tb_counter_bcd_n.sv
// Scoreboard bench for counter_bcd_n: an integer-arithmetic model predicts each
// cycle's outputs, monitors compare on the falling edge.
module tb_counter_bcd_n;

  typedef struct packed {
    int cnt;
    int pc;
    bit tick;
    bit wrap;
    bit err;
  } mstate_t;

  typedef struct packed {
    logic [31:0] cnt;
    logic        tick;
    logic        wrap;
    logic        err;
    logic [55:0] hex;
  } exp_t;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic aclr = 1'b0;

  logic        en_a, up_a, load_a;
  logic [7:0]  load_val_a;
  logic [7:0]  cnt_a;
  logic        tick_a, wrap_a, load_err_a;
  logic [13:0] hex_a;

  logic        en_b, up_b, load_b;
  logic [3:0]  load_val_b;
  logic [3:0]  cnt_b;
  logic        tick_b, wrap_b, load_err_b;
  logic [6:0]  hex_b;

  exp_t qa[$];
  exp_t qb[$];
  mstate_t sa = '0;
  mstate_t sb = '0;

  always #5 clk = ~clk;

  counter_bcd_n #(.DIGITS(2), .DIV(4), .MOD(60)) dut_a (
    .clk(clk), .aclr(aclr), .en(en_a), .up(up_a), .load(load_a),
    .load_val(load_val_a), .cnt(cnt_a), .tick(tick_a), .wrap(wrap_a),
    .load_err(load_err_a), .hex(hex_a)
  );

  counter_bcd_n #(.DIGITS(1), .DIV(1), .MOD(10)) dut_b (
    .clk(clk), .aclr(aclr), .en(en_b), .up(up_b), .load(load_b),
    .load_val(load_val_b), .cnt(cnt_b), .tick(tick_b), .wrap(wrap_b),
    .load_err(load_err_b), .hex(hex_b)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int div, input int md,
                                    input int digits, input bit en, input bit up,
                                    input bit load, input logic [31:0] lv);
    mstate_t n;
    bit ok;
    int val;
    int w;
    logic [3:0] d;
    n = s;
    n.tick = 0;
    n.wrap = 0;
    n.err = 0;
    if (load) begin
      ok = 1;
      val = 0;
      w = 1;
      for (int i = 0; i < digits; i++) begin
        d = lv[4*i +: 4];
        if (d > 4'd9) ok = 0;
        val = val + int'(d) * w;
        w = w * 10;
      end
      if (val >= md) ok = 0;
      n.cnt = ok ? val : 0;
      n.err = !ok;
      n.pc = 0;
    end else if (en) begin
      if (s.pc == div - 1) begin
        n.pc = 0;
        n.tick = 1;
        if (up) begin
          n.wrap = (s.cnt == md - 1);
          n.cnt = (s.cnt + 1) % md;
        end else begin
          n.wrap = (s.cnt == 0);
          n.cnt = (s.cnt + md - 1) % md;
        end
      end else begin
        n.pc = s.pc + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(input mstate_t s, input int digits);
    exp_t e;
    logic [31:0] b;
    b = to_bcd(s.cnt);
    e.cnt = b;
    e.tick = s.tick;
    e.wrap = s.wrap;
    e.err = s.err;
    e.hex = '0;
    for (int i = 0; i < digits; i++) e.hex[7*i +: 7] = seg_of(b[4*i +: 4]);
    return e;
  endfunction

  // Reference models: advance on each clock edge, restart on reset.
  initial forever begin
    @(posedge clk or posedge aclr);
    if (aclr) begin
      sa = '0;
      sb = '0;
      qa.delete();
      qb.delete();
    end else begin
      sa = mstep(sa, 4, 60, 2, en_a, up_a, load_a, 32'(load_val_a));
      sb = mstep(sb, 1, 10, 1, en_b, up_b, load_b, 32'(load_val_b));
    end
    qa.push_back(mk_exp(sa, 2));
    qb.push_back(mk_exp(sb, 1));
  end

  initial forever begin : mon_a
    exp_t e;
    exp_t a;
    @(negedge clk);
    if (qa.size() > 0) begin
      e = qa.pop_front();
      a = {32'(cnt_a), tick_a, wrap_a, load_err_a, 56'(hex_a)};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sb_a t=%0t got cnt=%0h t/w/e=%b%b%b hex=%0h expected cnt=%0h t/w/e=%b%b%b hex=%0h",
                 $time, a.cnt, a.tick, a.wrap, a.err, a.hex, e.cnt, e.tick, e.wrap, e.err, e.hex);
      end
    end
  end

  initial forever begin : mon_b
    exp_t e;
    exp_t a;
    @(negedge clk);
    if (qb.size() > 0) begin
      e = qb.pop_front();
      a = {32'(cnt_b), tick_b, wrap_b, load_err_b, 56'(hex_b)};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sb_b t=%0t got cnt=%0h t/w/e=%b%b%b hex=%0h expected cnt=%0h t/w/e=%b%b%b hex=%0h",
                 $time, a.cnt, a.tick, a.wrap, a.err, a.hex, e.cnt, e.tick, e.wrap, e.err, e.hex);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_a_val(input logic [7:0] v);
    load_a = 1'b1;
    load_val_a = v;
    step();
    load_a = 1'b0;
  endtask

  initial begin
    int wraps;
    logic [31:0] tmp;
    en_a = 0; up_a = 1; load_a = 0; load_val_a = '0;
    en_b = 1; up_b = 1; load_b = 0; load_val_b = '0;
    #2 aclr = 1'b1;
    step(2);
    chk("reset_cnt_a", 64'(cnt_a), 64'h0);
    chk("reset_hex_a", 64'(hex_a), 64'({7'b0000001, 7'b0000001}));
    chk("reset_pulses_a", 64'({tick_a, wrap_a, load_err_a}), 64'h0);
    aclr = 1'b0;

    // DIV=1 single digit: counts every cycle, wraps once per ten.
    wraps = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("b_seq", 64'(cnt_b), 64'(k % 10));
      if (wrap_b) wraps++;
    end
    chk("b_wrap_count", 64'(wraps), 64'd2);

    // Up wrap from 58.
    load_a_val(8'h58);
    chk("load58", 64'(cnt_a), 64'h58);
    en_a = 1;
    step(3);
    chk("hold58", 64'({cnt_a, tick_a}), 64'({8'h58, 1'b0}));
    step();
    chk("tick59", 64'({cnt_a, tick_a, wrap_a}), 64'({8'h59, 2'b10}));
    step(4);
    chk("wrap00", 64'({cnt_a, tick_a, wrap_a}), 64'({8'h00, 2'b11}));
    step();
    chk("wrap_1cyc", 64'({tick_a, wrap_a}), 64'h0);

    // Asynchronous reset mid-count.
    step(5);
    #2 aclr = 1'b1;
    #1;
    chk("async_cnt", 64'(cnt_a), 64'h0);
    chk("async_hex", 64'(hex_a), 64'({7'b0000001, 7'b0000001}));
    @(posedge clk);
    #1 aclr = 1'b0;
    step(3);
    chk("post_rst_notick", 64'({cnt_a, tick_a}), 64'h0);
    step();
    chk("post_rst_tick", 64'({cnt_a, tick_a}), 64'({8'h01, 1'b1}));

    // Down: digit borrow then wrap to MOD-1.
    up_a = 0;
    load_a_val(8'h10);
    step(4);
    chk("down09", 64'({cnt_a, tick_a, wrap_a}), 64'({8'h09, 2'b10}));
    load_a_val(8'h00);
    step(4);
    chk("down59", 64'({cnt_a, tick_a, wrap_a}), 64'({8'h59, 2'b11}));

    // Enable hold at pc=2 for three cycles.
    up_a = 1;
    load_a_val(8'h30);
    step(2);
    en_a = 0;
    step(3);
    chk("en_hold", 64'({cnt_a, tick_a}), 64'({8'h30, 1'b0}));
    en_a = 1;
    step();
    chk("en_resume", 64'(tick_a), 64'h0);
    step();
    chk("en_tick", 64'({cnt_a, tick_a}), 64'({8'h31, 1'b1}));

    // Load validation.
    load_a_val(8'h42);
    chk("load42", 64'({cnt_a, load_err_a}), 64'({8'h42, 1'b0}));
    load_a_val(8'h75);
    chk("load75", 64'({cnt_a, load_err_a}), 64'({8'h00, 1'b1}));
    step();
    chk("err_1cyc", 64'(load_err_a), 64'h0);
    load_a_val(8'h3A);
    chk("load3A", 64'({cnt_a, load_err_a}), 64'({8'h00, 1'b1}));

    // Load on the tick edge.
    load_a_val(8'h10);
    step(3);
    load_a_val(8'h25);
    chk("collide", 64'({cnt_a, tick_a, wrap_a}), 64'({8'h25, 2'b00}));
    step(3);
    chk("collide_pc", 64'(tick_a), 64'h0);
    step();
    chk("collide_next", 64'({cnt_a, tick_a}), 64'({8'h26, 1'b1}));
    load_b = 1; load_val_b = 4'h5;
    step();
    load_b = 0;
    chk("b_collide", 64'({cnt_b, tick_b, wrap_b}), 64'({4'h5, 2'b00}));

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        aclr = 1'b1;
        #1;
        chk("rand_aclr", 64'({cnt_a, cnt_b}), 64'h0);
        @(posedge clk);
        #1 aclr = 1'b0;
      end
      en_a = ($urandom % 8) != 0;
      if (($urandom % 16) == 0) up_a = ~up_a;
      load_a = ($urandom % 24) == 0;
      if ($urandom % 2) begin
        tmp = to_bcd(int'($urandom % 60));
        load_val_a = tmp[7:0];
      end else begin
        load_val_a = 8'($urandom);
      end
      en_b = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) up_b = ~up_b;
      load_b = ($urandom % 16) == 0;
      load_val_b = 4'($urandom);
      step();
    end

    en_a = 0; en_b = 0; load_a = 0; load_b = 0;
    step(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_bcd_n.md
# counter_bcd_n

Parametrised N-digit decimal counter with a built-in clock prescaler, up/down mode, synchronous BCD load and arbitrary modulus. It drives one active-low seven-segment output per digit. It is the general-purpose successor to the single-digit seconds counter and is the timebase/display block for clocks, stopwatches and event counters on the 50 MHz board.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits, 1..8.
- `DIV`, 50000000: clock cycles per count tick, ≥1.
- `MOD`, 10000: count modulus, 2..10^DIGITS; the count runs 0..MOD-1.

Ports:
- `clk` in 1: system clock, rising edge.
- `aclr` in 1: asynchronous, active-high reset. The one clock and this reset polarity/synchronicity are fixed.
- `en` in 1: count enable; low freezes prescaler and count.
- `up` in 1: 1 = count up, 0 = count down; sampled at each tick.
- `load` in 1: synchronous load strobe.
- `load_val` in 4*DIGITS: BCD load value, digit 0 in [3:0].
- `cnt` out 4*DIGITS: current BCD count, digit 0 in [3:0].
- `tick` out 1: one-cycle pulse, high in the cycle a tick-driven update becomes visible.
- `wrap` out 1: one-cycle pulse, high in the cycle a wrap-around becomes visible.
- `load_err` out 1: one-cycle pulse after a rejected load.
- `hex` out 7*DIGITS: active-low segments, order a..g from MSB. Digit 0 is in [6:0].

## Operation
- Prescaler `pc` has width clogb2(DIV-1), minimum 1. On `en`=1 it counts 0..DIV-1 and wraps to 0. The internal tick condition is `en` && pc==DIV-1. With `en`=0, `pc` holds its value.
- `DIV`=1 gives an internal tick on every enabled cycle.
- On tick with `up`=1: `cnt` becomes cnt+1 in BCD, with per-digit carry. If cnt==MOD-1, `cnt` becomes 0 and `wrap` asserts.
- On tick with `up`=0: `cnt` becomes cnt-1 in BCD, with per-digit borrow. If cnt==0, `cnt` becomes MOD-1 and `wrap` asserts.
- `load`=1 has priority over tick, regardless of `en`. It clears `pc` to 0 and does not assert `tick` or `wrap`.
  - Valid load: every digit ≤9 and value <MOD. Then `cnt` becomes `load_val`.
  - Invalid load: `cnt` becomes 0 and `load_err` pulses.
- Internal register state never holds a digit >9 or a value ≥MOD.
- `hex` is a combinational decode of `cnt`, per digit:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100
  - 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100
  - any other code→1111111
- Reset values: `pc`=0, `cnt`=0, `tick`=0, `wrap`=0, `load_err`=0, every `hex` digit = 0000001.
- Reset mid-count has immediate effect, independent of `clk`. After `aclr` falls, the first tick occurs DIV enabled cycles later.

## Timing
- `cnt` updates on the rising edge where the internal tick condition is true.
- `tick` and `wrap` are registered and high for exactly the one cycle following that edge, aligned with the new `cnt`.
- Tick period is DIV cycles of continuous `en`. Deasserting `en` extends it by the number of disabled cycles.
- Load latency is 1 cycle: `cnt` shows `load_val` after the edge on which `load` was sampled. The next tick comes DIV enabled cycles after that edge.
- A load and a tick on the same edge resolve to the load only.
- A change of `up` takes effect on the next tick, with no extra latency.
- `hex` has 0-cycle latency from `cnt`.

## Structure
- Shared package `counters_pkg` holds:
  - `clogb2` constant function.
  - Seven-segment pattern constants and a digit-to-segment function.
  - A `MOD`-to-BCD constant function, used to derive the MOD-1 compare value at elaboration.
- One sub-module, `bcd_digit`: a single decimal digit with `inc`/`dec` enable, carry/borrow in and out, and synchronous load.
  - Instanced DIGITS times via generate.
  - The top holds the prescaler, the modulus compare, load validation and the output pulse registers.

## Test plan
- Reset: with DIGITS=2, DIV=4, MOD=60, assert `aclr` mid-count → `cnt`=00 and `hex`=0000001 twice immediately. No `tick` until 4 enabled cycles after release.
- Up wrap: `up`=1, `en`=1 from 58 → 59 after 4 cycles, then 00 after 4 more, with `wrap`=1 and `tick`=1 for exactly that one cycle.
- Down wrap and digit borrow: `up`=0, from 10 → 09 (no `wrap`), then from 00 → 59 with `wrap`=1.
- Enable hold: drop `en` for 3 cycles at pc=2 → the tick is delayed by exactly 3 cycles and `cnt` is unchanged meanwhile.
- Load: `load_val`=0x42 → `cnt`=42 next cycle and `pc` restarts. `load_val`=0x75 (≥MOD) → `cnt`=00 and `load_err` pulses. `load_val`=0x3A (digit >9) → `cnt`=00 and `load_err` pulses.
- Load/tick collision and `DIV`=1: a load on the tick edge gives `cnt`=`load_val` with no `tick`. With DIV=1, MOD=10, DIGITS=1 the count goes 0..9,0 on consecutive cycles, with `wrap` once per 10 cycles.
